// File: rtl/time_counter.sv
// -----------------------------------------------------------------------------
// time_counter
//   24-hour time-of-day counter (hh:mm:ss). Advances one second on each rising
//   edge of tick1Hz while in run mode. In edit mode (freeze=1) counting halts
//   and the field chosen by sel is stepped up/down by the inc/dec buttons,
//   wrapping within that field only.
//
// Ports:
//   clk      in   system clock, all state updates on rising edge
//   rst      in   asynchronous active-low reset
//   tick1Hz  in   1 Hz square wave (clk domain); each rising edge = one second
//   freeze   in   1 = edit mode, 0 = run mode
//   inc      in   increment button (clk domain), rising-edge active
//   dec      in   decrement button (clk domain), rising-edge active
//   sel      in   edit field: 00 none, 01 seconds, 10 minutes, 11 hours
//   ss       out  seconds 0-59
//   mm       out  minutes 0-59
//   hh       out  hours 0-23
//   dayroll  out  one-clk pulse on run-mode wrap 23:59:59 -> 00:00:00
// -----------------------------------------------------------------------------
module time_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick1Hz,
    input  logic       freeze,
    input  logic       inc,
    input  logic       dec,
    input  logic [1:0] sel,
    output logic [5:0] ss,
    output logic [5:0] mm,
    output logic [4:0] hh,
    output logic       dayroll
);

    localparam logic [1:0] SEL_SS = 2'b01;
    localparam logic [1:0] SEL_MM = 2'b10;
    localparam logic [1:0] SEL_HH = 2'b11;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    // Previous samples for rising-edge detection. Tick history is kept in
    // both modes so a tick already high when freeze drops is not counted.
    logic tick_q;
    logic inc_q;
    logic dec_q;

    logic tick_ev;
    logic inc_ev;
    logic dec_ev;
    logic edit_up;
    logic edit_dn;

    logic [5:0] ss_n;
    logic [5:0] mm_n;
    logic [4:0] hh_n;
    logic       roll_n;

    assign tick_ev = tick1Hz & ~tick_q;
    assign inc_ev  = inc & ~inc_q;
    assign dec_ev  = dec & ~dec_q;

    // Simultaneous inc and dec events cancel out.
    assign edit_up = freeze & inc_ev & ~dec_ev;
    assign edit_dn = freeze & dec_ev & ~inc_ev;

    // Step a 0..max field by +1/-1 with wrap, never touching other fields.
    function automatic logic [5:0] step6(input logic [5:0] v, input logic [5:0] max,
                                         input logic up);
        logic [5:0] r;
        if (up) r = (v == max) ? '0 : v + 6'd1;
        else    r = (v == '0) ? max : v - 6'd1;
        return r;
    endfunction

    function automatic logic [4:0] step5(input logic [4:0] v, input logic [4:0] max,
                                         input logic up);
        logic [4:0] r;
        if (up) r = (v == max) ? '0 : v + 5'd1;
        else    r = (v == '0) ? max : v - 5'd1;
        return r;
    endfunction

    always_comb begin
        ss_n   = ss;
        mm_n   = mm;
        hh_n   = hh;
        roll_n = 1'b0;

        if (!freeze) begin
            if (tick_ev) begin
                // Full carry chain resolves in one clock.
                if (ss == SEC_MAX) begin
                    ss_n = '0;
                    if (mm == MIN_MAX) begin
                        mm_n = '0;
                        if (hh == HOUR_MAX) begin
                            hh_n   = '0;
                            roll_n = 1'b1;
                        end else begin
                            hh_n = hh + 5'd1;
                        end
                    end else begin
                        mm_n = mm + 6'd1;
                    end
                end else begin
                    ss_n = ss + 6'd1;
                end
            end
        end else if (edit_up || edit_dn) begin
            case (sel)
                SEL_SS:  ss_n = step6(ss, SEC_MAX, edit_up);
                SEL_MM:  mm_n = step6(mm, MIN_MAX, edit_up);
                SEL_HH:  hh_n = step5(hh, HOUR_MAX, edit_up);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q  <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            ss      <= '0;
            mm      <= '0;
            hh      <= '0;
            dayroll <= 1'b0;
        end else begin
            tick_q  <= tick1Hz;
            inc_q   <= inc;
            dec_q   <= dec;
            ss      <= ss_n;
            mm      <= mm_n;
            hh      <= hh_n;
            dayroll <= roll_n;
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// -----------------------------------------------------------------------------
// tb_time_counter
//   Self-checking bench for time_counter. The reference model keeps time as a
//   single seconds-of-day integer and derives fields arithmetically.
// -----------------------------------------------------------------------------
module tb_time_counter;

    logic       clk;
    logic       rst;
    logic       tick1Hz;
    logic       freeze;
    logic       inc;
    logic       dec;
    logic [1:0] sel;
    logic [5:0] ss;
    logic [5:0] mm;
    logic [4:0] hh;
    logic       dayroll;

    int checks;
    int failures;

    // Reference model state
    int m_t;
    bit m_roll;
    bit p_tick;
    bit p_inc;
    bit p_dec;

    logic [17:0] obs;
    assign obs = {hh, mm, ss, dayroll};

    time_counter dut (
        .clk    (clk),
        .rst    (rst),
        .tick1Hz(tick1Hz),
        .freeze (freeze),
        .inc    (inc),
        .dec    (dec),
        .sel    (sel),
        .ss     (ss),
        .mm     (mm),
        .hh     (hh),
        .dayroll(dayroll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] exp_vec();
        int h, m, s;
        h = m_t / 3600;
        m = (m_t / 60) % 60;
        s = m_t % 60;
        return {5'(h), 6'(m), 6'(s), m_roll};
    endfunction

    function automatic logic [17:0] hms(input int h, input int m, input int s, input bit r);
        return {5'(h), 6'(m), 6'(s), r};
    endfunction

    task automatic model_reset();
        m_t    = 0;
        m_roll = 0;
        p_tick = 0;
        p_inc  = 0;
        p_dec  = 0;
    endtask

    // Drive one clock worth of inputs and advance the model by one clock.
    task automatic step(input bit tk, input bit fr, input bit ic, input bit dc,
                        input logic [1:0] s);
        int h, m, sc, d;
        bit te, ie, de;
        tick1Hz = tk;
        freeze  = fr;
        inc     = ic;
        dec     = dc;
        sel     = s;
        @(posedge clk);
        #1;
        te = tk && !p_tick;
        ie = ic && !p_inc;
        de = dc && !p_dec;
        m_roll = 0;
        if (!fr) begin
            if (te) begin
                m_roll = (m_t == 86399);
                m_t    = (m_t + 1) % 86400;
            end
        end else if (ie != de) begin
            h  = m_t / 3600;
            m  = (m_t / 60) % 60;
            sc = m_t % 60;
            d  = ie ? 1 : -1;
            case (s)
                2'b01:   sc = (sc + 60 + d) % 60;
                2'b10:   m  = (m + 60 + d) % 60;
                2'b11:   h  = (h + 24 + d) % 24;
                default: ;
            endcase
            m_t = h * 3600 + m * 60 + sc;
        end
        p_tick = tk;
        p_inc  = ic;
        p_dec  = dc;
    endtask

    task automatic test_reset();
        logic [17:0] e;
        rst = 1'b0;
        tick1Hz = 0; freeze = 0; inc = 0; dec = 0; sel = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 18'd0) begin
            failures++;
            $display("FAIL reset_initial got=%h required=%h", obs, 18'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 0, 2'b00);
            step(0, 0, 0, 0, 2'b00);
        end
        e = exp_vec();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL precount got=%h required=%h", obs, e);
        end
        // Assert reset between clock edges: must clear without waiting for clk.
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 18'd0) begin
            failures++;
            $display("FAIL async_reset got=%h required=%h", obs, 18'd0);
        end
        tick1Hz = 1; freeze = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== 18'd0) begin
            failures++;
            $display("FAIL reset_hold got=%h required=%h", obs, 18'd0);
        end
        tick1Hz = 0;
        #3;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 90; i++) begin
            step(1, 0, 0, 0, 2'b00);
            step(0, 0, 0, 0, 2'b00);
        end
        checks++;
        if (obs !== hms(0, 1, 30, 0)) begin
            failures++;
            $display("FAIL count90 got=%h required=%h", obs, hms(0, 1, 30, 0));
        end
    endtask

    task automatic test_edit_seconds();
        step(0, 1, 0, 0, 2'b01);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 1, 0, 2'b01);
            step(1, 1, 0, 0, 2'b01);
            step(0, 1, 0, 0, 2'b01);
            step(1, 1, 0, 0, 2'b01);
        end
        step(0, 1, 0, 0, 2'b01);
        checks++;
        if (obs !== hms(0, 1, 32, 0) || obs !== exp_vec()) begin
            failures++;
            $display("FAIL edit_ss got=%h required=%h", obs, hms(0, 1, 32, 0));
        end
    endtask

    task automatic test_edit_minutes();
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 1, 2'b10);
            step(0, 1, 0, 0, 2'b10);
            step(0, 1, 0, 0, 2'b10);
        end
        checks++;
        if (obs !== hms(0, 59, 32, 0) || obs !== exp_vec()) begin
            failures++;
            $display("FAIL edit_mm_wrap got=%h required=%h", obs, hms(0, 59, 32, 0));
        end
    endtask

    task automatic test_edit_hours();
        step(0, 1, 1, 0, 2'b11);
        step(0, 1, 0, 0, 2'b11);
        checks++;
        if (obs !== hms(1, 59, 32, 0)) begin
            failures++;
            $display("FAIL edit_hh got=%h required=%h", obs, hms(1, 59, 32, 0));
        end
        for (int i = 0; i < 22; i++) begin
            step(0, 1, 1, 0, 2'b11);
            step(0, 1, 0, 0, 2'b11);
        end
        checks++;
        if (obs !== hms(23, 59, 32, 0)) begin
            failures++;
            $display("FAIL edit_hh23 got=%h required=%h", obs, hms(23, 59, 32, 0));
        end
        step(0, 1, 1, 0, 2'b11);
        checks++;
        if (obs !== hms(0, 59, 32, 0)) begin
            failures++;
            $display("FAIL edit_hh_wrap got=%h required=%h", obs, hms(0, 59, 32, 0));
        end
        step(0, 1, 0, 0, 2'b11);
        checks++;
        if (dayroll !== 1'b0) begin
            failures++;
            $display("FAIL edit_no_dayroll got=%b required=0", dayroll);
        end
        step(0, 1, 1, 0, 2'b00);
        step(0, 1, 0, 0, 2'b00);
        checks++;
        if (obs !== hms(0, 59, 32, 0)) begin
            failures++;
            $display("FAIL sel00 got=%h required=%h", obs, hms(0, 59, 32, 0));
        end
        step(0, 1, 1, 1, 2'b01);
        step(0, 1, 0, 0, 2'b01);
        checks++;
        if (obs !== hms(0, 59, 32, 0) || obs !== exp_vec()) begin
            failures++;
            $display("FAIL inc_dec_same got=%h required=%h", obs, hms(0, 59, 32, 0));
        end
    endtask

    task automatic test_rollover();
        for (int i = 0; i < 27; i++) begin
            step(0, 1, 1, 0, 2'b01);
            step(0, 1, 0, 0, 2'b01);
        end
        step(0, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        checks++;
        if (obs !== hms(1, 0, 0, 0)) begin
            failures++;
            $display("FAIL hour_carry got=%h required=%h", obs, hms(1, 0, 0, 0));
        end
        step(0, 1, 0, 0, 2'b11);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 1, 2'b11);
            step(0, 1, 0, 0, 2'b11);
        end
        step(0, 1, 0, 1, 2'b10);
        step(0, 1, 0, 0, 2'b10);
        step(0, 1, 0, 1, 2'b01);
        step(0, 1, 0, 0, 2'b01);
        checks++;
        if (obs !== hms(23, 59, 59, 0)) begin
            failures++;
            $display("FAIL preset_235959 got=%h required=%h", obs, hms(23, 59, 59, 0));
        end
        step(0, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        checks++;
        if (obs !== hms(0, 0, 0, 1) || obs !== exp_vec()) begin
            failures++;
            $display("FAIL midnight got=%h required=%h", obs, hms(0, 0, 0, 1));
        end
        step(1, 0, 0, 0, 2'b00);
        checks++;
        if (obs !== hms(0, 0, 0, 0)) begin
            failures++;
            $display("FAIL dayroll_width got=%h required=%h", obs, hms(0, 0, 0, 0));
        end
        step(0, 0, 0, 0, 2'b00);
    endtask

    task automatic test_edge_semantics();
        logic [17:0] e;
        int s0;
        s0 = m_t % 60;
        step(0, 1, 0, 0, 2'b01);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 2'b01);
        step(0, 1, 0, 0, 2'b01);
        e = {obs[17:7], 6'((s0 + 1) % 60), 1'b0};
        checks++;
        if (obs !== e || obs !== exp_vec()) begin
            failures++;
            $display("FAIL held_inc got=%h required=%h", obs, e);
        end
        step(1, 1, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL tick_high_at_unfreeze got=%h required=%h", obs, e);
        end
        step(0, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        e = {obs[17:7], 6'((s0 + 2) % 60), 1'b0};
        checks++;
        if (obs !== exp_vec() || obs[6:1] !== e[6:1]) begin
            failures++;
            $display("FAIL resume_count got=%h required=%h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [17:0] e;
        bit tk, fr, ic, dc;
        logic [1:0] s;
        tk = 0; fr = 0; ic = 0; dc = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) tk = ~tk;
            if ($urandom_range(0, 15) == 0) fr = ~fr;
            ic = ($urandom_range(0, 2) == 0);
            dc = ($urandom_range(0, 3) == 0);
            s  = 2'($urandom_range(0, 3));
            step(tk, fr, ic, dc, s);
            e = exp_vec();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL random step=%0d got=%h required=%h", i, obs, e);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_edit_seconds();
        test_edit_minutes();
        test_edit_hours();
        test_rollover();
        test_edge_semantics();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
